// File: rtl/mips_host_bridge_pkg.sv
// Shared constants and types for the MIPS host bridge: word geometry and
// the input-side FSM state encoding.
package mips_host_bridge_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W         = 2;
  localparam int WORD_W         = BYTES_PER_WORD * 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2
  } in_state_t;

endpackage

// File: rtl/io_word_fifo.sv
// Word-wide synchronous FIFO with show-ahead read data; a push is accepted
// while full as long as a pop happens in the same cycle.
module io_word_fifo
  import mips_host_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_host_bridge.sv
// Host-side bridge for the multi-cycle MIPS core: byte stream in, one-cycle
// Jen word strobes out; InstDone results buffered and streamed back as bytes.
module mips_host_bridge
  import mips_host_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        Jen,
  output logic [31:0] Jin,
  input  logic [31:0] Jout,
  input  logic        InstDone,
  output logic        overflow,
  output logic [31:0] inst_count
);

  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);

  in_state_t         state;
  in_state_t         next_state;
  logic [BIDX_W-1:0] bidx;
  logic [BIDX_W-1:0] obidx;
  logic [WORD_W-1:0] asm_word;
  logic [WORD_W-1:0] jin_q;
  logic [WORD_W-1:0] head;
  logic              accept;
  logic              last_in;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  assign accept  = in_valid & in_ready;
  assign last_in = accept & (bidx == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= next_state;
  end

  // InstDone only completes a word once the FSM has moved past ISSUE.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    Jen        = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (last_in) next_state = ISSUE;
      end
      ISSUE: begin
        Jen        = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (InstDone) next_state = COLLECT;
      end
      default: next_state = COLLECT;
    endcase
  end

  // Jin is loaded with the completed word as its last byte arrives so it is
  // valid throughout ISSUE and holds afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_word <= '0;
      bidx     <= '0;
      jin_q    <= '0;
    end else if (accept) begin
      asm_word[{bidx, 3'b000} +: 8] <= in_data;
      bidx <= last_in ? '0 : bidx + BIDX_W'(1);
      if (last_in) jin_q <= {in_data, asm_word[WORD_W-9:0]};
    end
  end

  assign Jin = jin_q;

  assign pop  = out_valid & out_ready & (obidx == LAST_BYTE);
  assign push = InstDone & (~full | pop);

  io_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (Jout),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_count <= '0;
      overflow   <= 1'b0;
      obidx      <= '0;
    end else begin
      if (InstDone)                inst_count <= inst_count + 32'd1;
      if (InstDone & full & ~pop)  overflow   <= 1'b1;
      if (out_valid & out_ready)   obidx      <= pop ? '0 : obidx + BIDX_W'(1);
    end
  end

  assign out_valid = ~empty;
  assign out_data  = empty ? 8'h00 : head[{obidx, 3'b000} +: 8];

endmodule

// File: tb/tb_mips_host_bridge.sv
// Scoreboard bench for mips_host_bridge: directed stimulus queues expected
// Jin words and result bytes; a negedge monitor pops and compares them.
module tb_mips_host_bridge;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        Jen;
  logic [31:0] Jin;
  logic [31:0] Jout;
  logic        InstDone;
  logic        overflow;
  logic [31:0] inst_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_words [$];
  logic [7:0]  exp_bytes [$];
  bit          prev_stall = 0;
  logic [7:0]  prev_data  = 8'h00;

  mips_host_bridge #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .Jen        (Jen),
    .Jin        (Jin),
    .Jout       (Jout),
    .InstDone   (InstDone),
    .overflow   (overflow),
    .inst_count (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL send_byte: byte %h not accepted, required acceptance", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_words.push_back(w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  // One-cycle InstDone; keep=1 means the word must come back on out_data.
  task automatic pulse_done(input logic [31:0] w, input bit keep);
    if (keep) begin
      exp_bytes.push_back(w[7:0]);
      exp_bytes.push_back(w[15:8]);
      exp_bytes.push_back(w[23:16]);
      exp_bytes.push_back(w[31:24]);
    end
    InstDone = 1'b1;
    Jout     = w;
    @(posedge clk);
    #1;
    InstDone = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_in_ready"},   in_ready,   32'd1);
    check_output({tag, "_out_valid"},  out_valid,  32'd0);
    check_output({tag, "_out_data"},   out_data,   32'd0);
    check_output({tag, "_jen"},        Jen,        32'd0);
    check_output({tag, "_jin"},        Jin,        32'd0);
    check_output({tag, "_overflow"},   overflow,   32'd0);
    check_output({tag, "_inst_count"}, inst_count, 32'd0);
  endtask

  // Monitor: compares every Jen strobe and every result-byte handshake
  // against the scoreboard, and checks out_data holds while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check_output("hold_valid", out_valid, 32'd1);
        check_output("hold_data",  out_data,  prev_data);
      end
      if (Jen) begin
        if (exp_words.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL jen_unexpected: Jin=%h, required no strobe", Jin);
        end else begin
          check_output("jin_word", Jin, exp_words.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL byte_unexpected: out_data=%h, required no byte", out_data);
        end else begin
          check_output("out_byte", out_data, exp_bytes.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    Jout      = 32'h0;
    InstDone  = 1'b0;
    idle(2);
    check_reset_values("reset");
    rst = 1'b0;
    out_ready = 1'b1;

    $display("[TB] word assembly and result return");
    send_word(32'h12345678);
    idle(2);
    check_output("wait_in_ready", in_ready, 32'd0);
    pulse_done(32'hDEADBEEF, 1);
    idle(6);
    check_output("count_after_first", inst_count, 32'd1);
    check_output("collect_in_ready", in_ready, 32'd1);
    check_output("first_drained", exp_bytes.size(), 32'd0);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    pulse_done(32'hCAFEF00D, 1);
    for (int i = 0; i < 8; i++) begin
      out_ready = (i % 2 == 0);
      idle(1);
    end
    out_ready = 1'b0;
    check_output("bp_drained", exp_bytes.size(), 32'd0);
    check_output("bp_empty", out_valid, 32'd0);

    $display("[TB] fill, full with pop, overflow");
    pulse_done(32'h11111111, 1);
    pulse_done(32'h22222222, 1);
    pulse_done(32'h33333333, 1);
    pulse_done(32'h44444444, 1);
    check_output("full_valid", out_valid, 32'd1);
    check_output("full_no_overflow", overflow, 32'd0);
    out_ready = 1'b1;
    idle(3);
    pulse_done(32'h55555555, 1);
    out_ready = 1'b0;
    check_output("pop_push_no_overflow", overflow, 32'd0);
    pulse_done(32'h66666666, 0);
    check_output("overflow_set", overflow, 32'd1);
    check_output("count_after_fill", inst_count, 32'd8);
    out_ready = 1'b1;
    idle(20);
    check_output("fill_drained", exp_bytes.size(), 32'd0);
    check_output("fill_empty", out_valid, 32'd0);
    check_output("overflow_sticky", overflow, 32'd1);

    $display("[TB] reset mid-word");
    out_ready = 1'b0;
    pulse_done(32'h55667788, 0);
    check_output("pre_reset_valid", out_valid, 32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    idle(1);
    check_reset_values("midreset");
    rst = 1'b0;
    out_ready = 1'b1;
    send_word(32'h04030201);
    pulse_done(32'h0BADF00D, 1);
    idle(2);
    check_output("issue_done_ignored", in_ready, 32'd0);
    pulse_done(32'h600DCAFE, 1);
    idle(10);
    check_output("final_in_ready", in_ready, 32'd1);
    check_output("final_count", inst_count, 32'd2);
    check_output("final_jin_hold", Jin, 32'h04030201);
    check_output("final_words_left", exp_words.size(), 32'd0);
    check_output("final_bytes_left", exp_bytes.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
